// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit to pipeline-control bundle: stall/flush requests in,
// register enables/clears, per-stage valids and performance counters out.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             CntClear;
  logic             EnableF;
  logic             EnableD;
  logic             ClearD;
  logic             ClearE;
  logic             ValidD;
  logic             ValidE;
  logic             ValidM;
  logic             ValidW;
  logic             RetireW;
  logic             Running;
  logic             ProtoErr;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstRetCount;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output StallF, StallD, FlushD, FlushE, CntClear,
    input  EnableF, EnableD, ClearD, ClearE,
    input  ValidD, ValidE, ValidM, ValidW, RetireW, Running, ProtoErr,
    input  CycleCount, InstRetCount, StallCount, FlushCount
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, CntClear,
    output EnableF, EnableD, ClearD, ClearE,
    output ValidD, ValidE, ValidM, ValidW, RetireW, Running, ProtoErr,
    output CycleCount, InstRetCount, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Consumer of hazard stall/flush requests: register enables/clears, stage
// valid tracking, start-up sequencing and saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_active;
  logic             r_valid_d;
  logic             r_valid_e;
  logic             r_valid_m;
  logic             r_valid_w;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET: w_state_next = S_FILL;
      S_FILL:  if (r_valid_w) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_RESET;
    endcase
  end

  always_comb begin
    w_active    = (r_state != S_RESET);
    bus.EnableF = ~bus.StallF & w_active;
    bus.EnableD = ~bus.StallD;
    bus.ClearD  = bus.FlushD;
    bus.ClearE  = bus.FlushE;
    bus.RetireW = r_valid_w;
    bus.Running = (r_state == S_RUN);
  end

  // Valid shift; flush takes priority over stall in D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_valid_e <= 1'b0;
      r_valid_m <= 1'b0;
      r_valid_w <= 1'b0;
    end else begin
      r_valid_d <= bus.FlushD ? 1'b0 : (bus.StallD ? r_valid_d : w_active);
      r_valid_e <= bus.FlushE ? 1'b0 : r_valid_d;
      r_valid_m <= r_valid_e;
      r_valid_w <= r_valid_m;
    end
  end

  // Counters: clear wins over that cycle's increment; ProtoErr is reset-only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_ret_cnt   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (bus.CntClear) begin
        r_cycle_cnt <= '0;
        r_ret_cnt   <= '0;
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        r_cycle_cnt <= sat_inc(r_cycle_cnt, w_active);
        r_ret_cnt   <= sat_inc(r_ret_cnt, r_valid_w);
        r_stall_cnt <= sat_inc(r_stall_cnt, bus.StallD & ~bus.FlushD);
        r_flush_cnt <= sat_inc(r_flush_cnt, bus.FlushD);
      end
      if (bus.StallF != bus.StallD) r_proto_err <= 1'b1;
    end
  end

  assign bus.ValidD       = r_valid_d;
  assign bus.ValidE       = r_valid_e;
  assign bus.ValidM       = r_valid_m;
  assign bus.ValidW       = r_valid_w;
  assign bus.ProtoErr     = r_proto_err;
  assign bus.CycleCount   = r_cycle_cnt;
  assign bus.InstRetCount = r_ret_cnt;
  assign bus.StallCount   = r_stall_cnt;
  assign bus.FlushCount   = r_flush_cnt;

endmodule
